// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory
// req/gnt handshake and the decode-side instruction outputs.
interface pc_fetch_ctrl_if #(
  parameter int N = 32
);
  logic          stall_i;
  logic          redirect_i;
  logic [N-1:0]  target_i;
  logic          halt_i;
  logic          imem_req_o;
  logic [N-1:0]  imem_addr_o;
  logic          imem_gnt_i;
  logic [31:0]   imem_rdata_i;
  logic [31:0]   instr_o;
  logic [N-1:0]  pc_o;
  logic          instr_valid_o;
  logic          halted_o;

  // Controller side: drives the fetch request and decode outputs.
  modport master (
    input  stall_i, redirect_i, target_i, halt_i, imem_gnt_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, halted_o
  );

  // Environment side: pipeline control, instruction memory and decode.
  modport slave (
    output stall_i, redirect_i, target_i, halt_i, imem_gnt_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, halted_o
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter controller for the instruction-fetch stage.
// Holds the PC, issues fetches through a req/gnt handshake and hands each
// fetched word, tagged with its PC, to decode one cycle after the grant.
module pc_fetch_ctrl #(
  parameter int           N          = 32,
  parameter logic [N-1:0] RESET_ADDR = '0,
  parameter int           INC        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pc_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] pc_reg;
  logic [31:0]  instr_reg;
  logic [N-1:0] pc_out_reg;
  logic         valid_reg;
  logic         halted_reg;
  logic         fetch_req;
  logic         fetch_accept;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state: IDLE always moves on, a halt (not pre-empted by a redirect)
  // parks the controller in HALTED until reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = REQ;
      REQ:     if (!bus.redirect_i && bus.halt_i) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // Request is suppressed in any redirect, halt or stall cycle so memory
  // never accepts a fetch that would be thrown away.
  always_comb begin
    fetch_req    = (state_reg == REQ) && !bus.stall_i && !bus.redirect_i && !bus.halt_i;
    fetch_accept = fetch_req && bus.imem_gnt_i;
  end

  // PC and decode-side registers, priority redirect > halt > stall > grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg     <= RESET_ADDR;
      instr_reg  <= '0;
      pc_out_reg <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else if (state_reg != REQ) begin
      valid_reg  <= 1'b0;
    end else if (bus.redirect_i) begin
      pc_reg     <= bus.target_i & ~N'(3);
      valid_reg  <= 1'b0;
    end else if (bus.halt_i) begin
      valid_reg  <= 1'b0;
      halted_reg <= 1'b1;
    end else if (bus.stall_i) begin
      valid_reg  <= valid_reg;
    end else if (fetch_accept) begin
      instr_reg  <= bus.imem_rdata_i;
      pc_out_reg <= pc_reg;
      valid_reg  <= 1'b1;
      pc_reg     <= pc_reg + N'(INC);
    end else begin
      valid_reg  <= 1'b0;
    end
  end

  assign bus.imem_req_o    = fetch_req;
  assign bus.imem_addr_o   = pc_reg;
  assign bus.instr_o       = instr_reg;
  assign bus.pc_o          = pc_out_reg;
  assign bus.instr_valid_o = valid_reg;
  assign bus.halted_o      = halted_reg;

endmodule
